// File: rtl/crm_loader.sv
// CRAM loader: assembles an 84-bit microword from four 21-bit pieces, writes it
// to the control RAM and optionally reads it back to verify the write.
module crm_loader #(
  parameter int VERIFY = 1
) (
  input  logic        eboxClk,
  input  logic        eboxReset,
  input  logic        loadAdrValid,
  input  logic [0:11] loadAdr,
  input  logic        pieceValid,
  output logic        pieceReady,
  input  logic [0:1]  pieceSel,
  input  logic [0:20] pieceData,
  input  logic        writeGo,
  output logic [0:11] cramAddr,
  output logic [0:83] cramDin,
  output logic        cramWe,
  input  logic [0:83] cramDout,
  output logic        busy,
  output logic        done,
  output logic        verifyErr,
  output logic [0:11] errAdr,
  output logic        seqErr,
  output logic [0:11] wordCount
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CHECK} state_e;

  state_e      state_q, state_d;
  logic [0:11] adr_q, adr_d;
  logic [0:83] word_q, word_d;
  logic [3:0]  mask_q, mask_d;
  logic [0:11] count_q, count_d;
  logic        verifyErr_q, verifyErr_d;
  logic [0:11] errAdr_q, errAdr_d;
  logic        seqErr_q, seqErr_d;
  logic        complete;

  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      word_q      <= '0;
      mask_q      <= '0;
      count_q     <= '0;
      verifyErr_q <= 1'b0;
      errAdr_q    <= '0;
      seqErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      word_q      <= word_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      verifyErr_q <= verifyErr_d;
      errAdr_q    <= errAdr_d;
      seqErr_q    <= seqErr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    word_d      = word_q;
    mask_d      = mask_q;
    count_d     = count_q;
    verifyErr_d = verifyErr_q;
    errAdr_d    = errAdr_q;
    seqErr_d    = seqErr_q;
    cramWe      = 1'b0;
    complete    = 1'b0;

    case (state_q)
      IDLE: begin
        if (loadAdrValid) adr_d = loadAdr;
        if (pieceValid) begin
          case (pieceSel)
            2'd0:    begin word_d[0:20]  = pieceData; mask_d[0] = 1'b1; end
            2'd1:    begin word_d[21:41] = pieceData; mask_d[1] = 1'b1; end
            2'd2:    begin word_d[42:62] = pieceData; mask_d[2] = 1'b1; end
            default: begin word_d[63:83] = pieceData; mask_d[3] = 1'b1; end
          endcase
        end
        // Same-cycle pieces and address loads are folded in before the commit test.
        if (writeGo) begin
          if (&mask_d) state_d = WRITE;
          else         seqErr_d = 1'b1;
        end
      end
      WRITE: begin
        cramWe = 1'b1;
        if (VERIFY != 0) state_d = READ;
        else             complete = 1'b1;
      end
      READ: state_d = CHECK;
      CHECK: begin
        // Only the first mismatch is recorded; errAdr is frozen once verifyErr is set.
        if ((cramDout != word_q) && !verifyErr_q) begin
          verifyErr_d = 1'b1;
          errAdr_d    = adr_q;
        end
        complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      adr_d   = adr_q + 12'd1;
      count_d = count_q + 12'd1;
      mask_d  = '0;
      state_d = IDLE;
    end
  end

  assign done       = complete;
  assign pieceReady = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cramAddr   = adr_q;
  assign cramDin    = word_q;
  assign verifyErr  = verifyErr_q;
  assign errAdr     = errAdr_q;
  assign seqErr     = seqErr_q;
  assign wordCount  = count_q;

endmodule

// File: tb/tb_crm_loader.sv
// Bench for crm_loader: a verifying instance and a non-verifying instance share
// stimulus, each backed by its own CRAM model with a one-cycle registered read.
module tb_crm_loader;

  logic        eboxClk = 1'b0;
  logic        eboxReset;
  logic        loadAdrValid;
  logic [11:0] loadAdr;
  logic        pieceValid;
  logic [1:0]  pieceSel;
  logic [20:0] pieceData;
  logic        writeGo;

  logic        pieceReady1, cramWe1, busy1, done1, verifyErr1, seqErr1;
  logic [11:0] cramAddr1, errAdr1, wordCount1;
  logic [83:0] cramDin1, cramDout1;
  logic        pieceReady0, cramWe0, busy0, done0, verifyErr0, seqErr0;
  logic [11:0] cramAddr0, errAdr0, wordCount0;
  logic [83:0] cramDin0, cramDout0;

  logic [83:0] mem1 [4096];
  logic [83:0] mem0 [4096];
  logic        corrupt [4096];
  int          we1Count = 0;
  int          we0Count = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] adr;
    logic [20:0] piece;
    logic        corrupt;
    logic        together;
    logic        expVerifyErr;
    logic [11:0] expErrAdr;
    logic [11:0] expNextAdr;
    logic [11:0] expCount;
  } vec_t;

  vec_t        vecs [4];
  vec_t        v;
  logic [83:0] expWord;
  int          w1, w0, expWrites;

  logic [11:0] mAdr, mCount, writeAdr, rAdr;
  logic [20:0] mPiece [4];
  logic [3:0]  mMask;
  logic        mSeqErr;
  logic [1:0]  rSel;
  logic [20:0] rData;
  logic        withPiece, withLoad;
  int          nPre;

  always #5 eboxClk = ~eboxClk;

  crm_loader #(.VERIFY(1)) dut1 (
    .eboxClk(eboxClk), .eboxReset(eboxReset),
    .loadAdrValid(loadAdrValid), .loadAdr(loadAdr),
    .pieceValid(pieceValid), .pieceReady(pieceReady1),
    .pieceSel(pieceSel), .pieceData(pieceData), .writeGo(writeGo),
    .cramAddr(cramAddr1), .cramDin(cramDin1), .cramWe(cramWe1), .cramDout(cramDout1),
    .busy(busy1), .done(done1), .verifyErr(verifyErr1), .errAdr(errAdr1),
    .seqErr(seqErr1), .wordCount(wordCount1)
  );

  crm_loader #(.VERIFY(0)) dut0 (
    .eboxClk(eboxClk), .eboxReset(eboxReset),
    .loadAdrValid(loadAdrValid), .loadAdr(loadAdr),
    .pieceValid(pieceValid), .pieceReady(pieceReady0),
    .pieceSel(pieceSel), .pieceData(pieceData), .writeGo(writeGo),
    .cramAddr(cramAddr0), .cramDin(cramDin0), .cramWe(cramWe0), .cramDout(cramDout0),
    .busy(busy0), .done(done0), .verifyErr(verifyErr0), .errAdr(errAdr0),
    .seqErr(seqErr0), .wordCount(wordCount0)
  );

  // CRAM models; the verifying one can flip bit 83 (the LSB here) on readback.
  always @(posedge eboxClk) begin
    if (cramWe1) begin
      mem1[cramAddr1] <= cramDin1;
      we1Count <= we1Count + 1;
    end
    cramDout1 <= mem1[cramAddr1] ^ (corrupt[cramAddr1] ? 84'd1 : 84'd0);
    if (cramWe0) begin
      mem0[cramAddr0] <= cramDin0;
      we0Count <= we0Count + 1;
    end
    cramDout0 <= mem0[cramAddr0];
  end

  task automatic checkOutput(input string name, input logic [83:0] actual, input logic [83:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; returns at the negedge after the sampling edge.
  task automatic applyStimulus(input logic lv, input logic [11:0] la, input logic pv,
                               input logic [1:0] ps, input logic [20:0] pd, input logic wg);
    loadAdrValid = lv;
    loadAdr      = la;
    pieceValid   = pv;
    pieceSel     = ps;
    pieceData    = pd;
    writeGo      = wg;
    @(negedge eboxClk);
    loadAdrValid = 1'b0;
    pieceValid   = 1'b0;
    writeGo      = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge eboxClk);
  endtask

  task automatic doReset();
    eboxReset = 1'b1;
    @(negedge eboxClk);
    eboxReset = 1'b0;
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    eboxReset = 1'b1; loadAdrValid = 1'b0; loadAdr = '0;
    pieceValid = 1'b0; pieceSel = '0; pieceData = '0; writeGo = 1'b0;
    for (int i = 0; i < 4096; i++) corrupt[i] = 1'b0;
    vecs[0] = '{12'o100,  21'o1234567, 1'b0, 1'b0, 1'b0, 12'o0,   12'o101, 12'd1};
    vecs[1] = '{12'o200,  21'o7654321, 1'b1, 1'b0, 1'b1, 12'o200, 12'o201, 12'd2};
    vecs[2] = '{12'o201,  21'o0000001, 1'b1, 1'b0, 1'b1, 12'o200, 12'o202, 12'd3};
    vecs[3] = '{12'o7777, 21'o7777777, 1'b0, 1'b1, 1'b1, 12'o200, 12'o0,   12'd4};
    idleCycles(2);
    eboxReset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_busy1", busy1, 0);
    checkOutput("rst_ready1", pieceReady1, 1);
    checkOutput("rst_we1", cramWe1, 0);
    checkOutput("rst_done1", done1, 0);
    checkOutput("rst_addr1", cramAddr1, 0);
    checkOutput("rst_count1", wordCount1, 0);
    checkOutput("rst_verr1", verifyErr1, 0);
    checkOutput("rst_seqerr1", seqErr1, 0);
    checkOutput("rst_erradr1", errAdr1, 0);
    checkOutput("rst_din1", cramDin1, 0);
    checkOutput("rst_busy0", busy0, 0);

    // Directed words with full latency checks on both instances.
    $display("[TB] directed table");
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      corrupt[v.adr] = v.corrupt;
      if (!v.together) applyStimulus(1'b1, v.adr, 1'b0, 2'd0, 21'd0, 1'b0);
      for (int p = 0; p < 3; p++)
        applyStimulus(1'b0, 12'd0, 1'b1, 2'(p), 21'(v.piece + 21'(p)), 1'b0);
      w1 = we1Count; w0 = we0Count;
      expWord = {v.piece, 21'(v.piece + 21'd1), 21'(v.piece + 21'd2), 21'(v.piece + 21'd3)};
      applyStimulus(v.together, v.adr, 1'b1, 2'd3, 21'(v.piece + 21'd3), 1'b1);
      checkOutput("we1_n1", cramWe1, 1);
      checkOutput("addr1_n1", cramAddr1, v.adr);
      checkOutput("din1_n1", cramDin1, expWord);
      checkOutput("we0_n1", cramWe0, 1);
      checkOutput("done0_n1", done0, 1);
      checkOutput("done1_n1", done1, 0);
      idleCycles(1);
      checkOutput("we1_n2", cramWe1, 0);
      checkOutput("we0_n2", cramWe0, 0);
      checkOutput("ready0_n2", pieceReady0, 1);
      checkOutput("done1_n2", done1, 0);
      idleCycles(1);
      checkOutput("done1_n3", done1, 1);
      checkOutput("ready1_n3", pieceReady1, 0);
      idleCycles(1);
      checkOutput("ready1_n4", pieceReady1, 1);
      checkOutput("verr1", verifyErr1, v.expVerifyErr);
      checkOutput("erradr1", errAdr1, v.expErrAdr);
      checkOutput("nextadr1", cramAddr1, v.expNextAdr);
      checkOutput("count1", wordCount1, v.expCount);
      checkOutput("nextadr0", cramAddr0, v.expNextAdr);
      checkOutput("count0", wordCount0, v.expCount);
      checkOutput("verr0", verifyErr0, 0);
      checkOutput("wecnt1", 84'(we1Count - w1), 1);
      checkOutput("wecnt0", 84'(we0Count - w0), 1);
      checkOutput("mem1", mem1[v.adr], expWord);
    end

    // Incomplete word: pieces 0, 1, 3 then writeGo.
    $display("[TB] incomplete word");
    applyStimulus(1'b0, 12'd0, 1'b1, 2'd0, 21'd5, 1'b0);
    applyStimulus(1'b0, 12'd0, 1'b1, 2'd1, 21'd6, 1'b0);
    applyStimulus(1'b0, 12'd0, 1'b1, 2'd3, 21'd7, 1'b0);
    w1 = we1Count; w0 = we0Count;
    applyStimulus(1'b0, 12'd0, 1'b0, 2'd0, 21'd0, 1'b1);
    checkOutput("inc_we1", cramWe1, 0);
    checkOutput("inc_we0", cramWe0, 0);
    checkOutput("inc_busy1", busy1, 0);
    checkOutput("inc_seqerr1", seqErr1, 1);
    checkOutput("inc_seqerr0", seqErr0, 1);
    idleCycles(3);
    checkOutput("inc_count1", wordCount1, 4);
    checkOutput("inc_wecnt1", 84'(we1Count - w1), 0);

    // Reset while in WRITE: piece 2 completes the mask left over above.
    $display("[TB] reset mid-write");
    applyStimulus(1'b0, 12'd0, 1'b1, 2'd2, 21'd8, 1'b0);
    applyStimulus(1'b0, 12'd0, 1'b0, 2'd0, 21'd0, 1'b1);
    checkOutput("mid_we1_write", cramWe1, 1);
    doReset();
    checkOutput("mid_we1", cramWe1, 0);
    checkOutput("mid_we0", cramWe0, 0);
    checkOutput("mid_busy1", busy1, 0);
    checkOutput("mid_done1", done1, 0);
    checkOutput("mid_count1", wordCount1, 0);
    checkOutput("mid_addr1", cramAddr1, 0);
    checkOutput("mid_din1", cramDin1, 0);
    checkOutput("mid_verr1", verifyErr1, 0);
    checkOutput("mid_erradr1", errAdr1, 0);
    checkOutput("mid_seqerr1", seqErr1, 0);
    // Partial word must be gone: piece 3 alone is not enough.
    applyStimulus(1'b0, 12'd0, 1'b1, 2'd3, 21'd9, 1'b0);
    w1 = we1Count;
    applyStimulus(1'b0, 12'd0, 1'b0, 2'd0, 21'd0, 1'b1);
    checkOutput("discard_we1", cramWe1, 0);
    checkOutput("discard_seqerr1", seqErr1, 1);
    doReset();

    // writeGo during READ is ignored by the verifying instance.
    $display("[TB] writeGo during read");
    applyStimulus(1'b1, 12'o300, 1'b0, 2'd0, 21'd0, 1'b0);
    for (int p = 0; p < 4; p++) applyStimulus(1'b0, 12'd0, 1'b1, 2'(p), 21'(p + 40), 1'b0);
    w1 = we1Count;
    applyStimulus(1'b0, 12'd0, 1'b0, 2'd0, 21'd0, 1'b1);
    idleCycles(1);
    applyStimulus(1'b0, 12'd0, 1'b0, 2'd0, 21'd0, 1'b1);
    checkOutput("rd_done1", done1, 1);
    idleCycles(3);
    checkOutput("rd_busy1", busy1, 0);
    checkOutput("rd_wecnt1", 84'(we1Count - w1), 1);
    checkOutput("rd_count1", wordCount1, 1);
    checkOutput("rd_seqerr1", seqErr1, 0);
    checkOutput("rd_addr1", cramAddr1, 12'o301);
    doReset();

    // Randomized transactions against a word-level model.
    $display("[TB] random transactions");
    mAdr = '0; mCount = '0; mMask = '0; mSeqErr = 1'b0;
    for (int k = 0; k < 4; k++) mPiece[k] = '0;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        rAdr = 12'($urandom);
        applyStimulus(1'b1, rAdr, 1'b0, 2'd0, 21'd0, 1'b0);
        mAdr = rAdr;
      end
      nPre = $urandom_range(0, 4);
      for (int k = 0; k < nPre; k++) begin
        rSel = 2'($urandom); rData = 21'($urandom);
        applyStimulus(1'b0, 12'd0, 1'b1, rSel, rData, 1'b0);
        mPiece[rSel] = rData; mMask[rSel] = 1'b1;
      end
      withPiece = 1'($urandom); withLoad = ($urandom_range(0, 3) == 0);
      rSel = 2'($urandom); rData = 21'($urandom); rAdr = 12'($urandom);
      if (withLoad) mAdr = rAdr;
      if (withPiece) begin mPiece[rSel] = rData; mMask[rSel] = 1'b1; end
      w1 = we1Count; w0 = we0Count;
      applyStimulus(withLoad, rAdr, withPiece, rSel, rData, 1'b1);
      idleCycles(3);
      if (mMask == 4'hF) begin
        expWord = {mPiece[0], mPiece[1], mPiece[2], mPiece[3]};
        writeAdr = mAdr;
        mAdr = mAdr + 12'd1; mCount = mCount + 12'd1; mMask = '0; expWrites = 1;
      end else begin
        mSeqErr = 1'b1; expWrites = 0;
      end
      checkOutput("rnd_ready1", pieceReady1, 1);
      checkOutput("rnd_wecnt1", 84'(we1Count - w1), 84'(expWrites));
      checkOutput("rnd_wecnt0", 84'(we0Count - w0), 84'(expWrites));
      checkOutput("rnd_count1", wordCount1, mCount);
      checkOutput("rnd_count0", wordCount0, mCount);
      checkOutput("rnd_addr1", cramAddr1, mAdr);
      checkOutput("rnd_addr0", cramAddr0, mAdr);
      checkOutput("rnd_seqerr1", seqErr1, mSeqErr);
      checkOutput("rnd_seqerr0", seqErr0, mSeqErr);
      checkOutput("rnd_verr1", verifyErr1, 0);
      if (expWrites == 1) begin
        checkOutput("rnd_mem1", mem1[writeAdr], expWord);
        checkOutput("rnd_mem0", mem0[writeAdr], expWord);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
